alu_serial_seq: RTL and testbench



---
 rtl/alu_serial_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_serial_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial ALU sequencer. It accepts an (opcode, A, B)
//               request, evaluates it one bit per cycle from LSB to MSB, and
//               returns the WIDTH-bit result and the final carry over a
//               valid/ready response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  localparam logic [3:0] c_op_add   = 4'd0;
  localparam logic [3:0] c_op_sub   = 4'd1;
  localparam logic [3:0] c_op_and   = 4'd2;
  localparam logic [3:0] c_op_or    = 4'd3;
  localparam logic [3:0] c_op_nor   = 4'd4;
  localparam logic [3:0] c_op_xor   = 4'd5;
  localparam logic [3:0] c_op_xnor  = 4'd6;
  localparam logic [3:0] c_op_nand  = 4'd7;
  localparam logic [3:0] c_op_pass_a = 4'd8;
  localparam logic [3:0] c_op_pass_b = 4'd9;
  localparam logic [3:0] c_op_zero  = 4'd10;
  localparam logic [3:0] c_op_slt   = 4'd11;
  localparam logic [3:0] c_op_sltu  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_lt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_cout;

  logic w_inv_b;
  logic w_arith;
  logic w_cmp;
  logic w_bb;
  logic w_sum;
  logic w_cnext;
  logic w_bit;

  // Subtract-style ops invert B and seed the carry with 1 (two's complement).
  assign w_inv_b = (r_op == c_op_sub) || (r_op == c_op_slt) || (r_op == c_op_sltu);
  assign w_cmp   = (r_op == c_op_slt) || (r_op == c_op_sltu);
  assign w_arith = (r_op == c_op_add) || w_inv_b;
  assign w_bb    = r_b[0] ^ w_inv_b;
  assign w_sum   = r_a[0] ^ w_bb ^ r_carry;
  assign w_cnext = (r_a[0] & w_bb) | (r_carry & (r_a[0] ^ w_bb));

  // Per-bit result select; logic ops use the uninverted B bit.
  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      c_op_add, c_op_sub, c_op_slt, c_op_sltu: w_bit = w_sum;
      c_op_and:    w_bit = r_a[0] & r_b[0];
      c_op_or:     w_bit = r_a[0] | r_b[0];
      c_op_nor:    w_bit = ~(r_a[0] | r_b[0]);
      c_op_xor:    w_bit = r_a[0] ^ r_b[0];
      c_op_xnor:   w_bit = ~(r_a[0] ^ r_b[0]);
      c_op_nand:   w_bit = ~(r_a[0] & r_b[0]);
      c_op_pass_a: w_bit = r_a[0];
      c_op_pass_b: w_bit = r_b[0];
      c_op_zero:   w_bit = 1'b0;
      default:     w_bit = 1'b0;
    endcase
  end

  // Sequencer FSM: accept, shift WIDTH bits, then present the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_op         <= 4'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_carry      <= 1'b0;
      r_lt         <= 1'b0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_op        <= req_opcode;
            r_a         <= req_a;
            r_b         <= req_b;
            r_res       <= '0;
            r_cnt       <= '0;
            r_carry     <= (req_opcode == c_op_sub) || (req_opcode == c_op_slt) ||
                           (req_opcode == c_op_sltu);
            r_req_ready <= 1'b0;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_res   <= {w_bit, r_res[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_cnext;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == c_last) begin
            // r_carry is the MSB carry-in here; cin^cout flags signed overflow.
            r_lt    <= (r_op == c_op_slt) ? ((r_carry ^ w_cnext) ^ w_sum) : ~w_cnext;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Response registers load once on the first DONE cycle, then hold.
          if (!r_rsp_valid) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_cmp ? {{(WIDTH-1){1'b0}}, r_lt} : r_res;
            r_rsp_cout   <= w_arith & r_carry;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_cout   = r_rsp_cout;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_seq
// Description : Self-checking bench for alu_serial_seq (WIDTH=8), directed
//               cases plus random operations against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opcode;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;

  int errors = 0;
  int checks = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {cout, result}.
  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    case (op)
      4'd0:  r = {1'b0, a} + {1'b0, b};
      4'd1:  r = {(a >= b), 8'(a - b)};
      4'd2:  r = {1'b0, a & b};
      4'd3:  r = {1'b0, a | b};
      4'd4:  r = {1'b0, ~(a | b)};
      4'd5:  r = {1'b0, a ^ b};
      4'd6:  r = {1'b0, ~(a ^ b)};
      4'd7:  r = {1'b0, ~(a & b)};
      4'd8:  r = {1'b0, a};
      4'd9:  r = {1'b0, b};
      4'd10: r = 9'd0;
      4'd11: r = {(a >= b), 7'd0, ($signed(a) < $signed(b))};
      4'd12: r = {(a >= b), 7'd0, (a < b)};
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  // Issue one request and check latency, result and carry; optional backpressure.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit backpressure);
    logic [8:0] exp;
    logic [7:0] held;
    int n;
    int w;
    exp = model(op, a, b);
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_accept", 64'(req_ready), 64'd1);
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_opcode = 4'($urandom);
    req_a      = 8'($urandom);
    req_b      = 8'($urandom);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (rsp_valid) break;
    end
    chk("latency", 64'(n), 64'(WIDTH + 1));
    chk("result", 64'(rsp_result), 64'(exp[7:0]));
    chk("cout", 64'(rsp_cout), 64'(exp[8]));
    chk("req_ready_in_done", 64'(req_ready), 64'd0);
    if (backpressure) begin
      held = rsp_result;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        req_valid = (i == 2);
        req_opcode = 4'd0;
        @(posedge clk);
        #1;
        chk("bp_valid_held", 64'(rsp_valid), 64'd1);
        chk("bp_result_stable", 64'(rsp_result), 64'(held));
        chk("bp_req_ready_low", 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("req_ready_rise", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [3:0] rop;
    int seen;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = 4'd0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    #23;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    run_op(4'd0,  8'hFF, 8'h01, 1'b0);
    run_op(4'd1,  8'h05, 8'h07, 1'b0);
    run_op(4'd6,  8'hF0, 8'hAA, 1'b0);
    run_op(4'd11, 8'h80, 8'h01, 1'b0);
    run_op(4'd11, 8'h7F, 8'h80, 1'b0);
    run_op(4'd12, 8'h80, 8'h01, 1'b0);
    run_op(4'd14, 8'hFF, 8'hFF, 1'b0);
    run_op(4'd3,  8'h5A, 8'h0F, 1'b1);

    // Reset in the middle of RUN (after bit 3 has been processed).
    @(negedge clk);
    req_opcode = 4'd0;
    req_a      = 8'h77;
    req_b      = 8'h11;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_result", 64'(rsp_result), 64'd0);
    chk("midrst_cout", 64'(rsp_cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 64'(seen), 64'd0);
    run_op(4'd0, 8'h12, 8'h34, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run_op(rop, ra, rb, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
